// File: rtl/pkcs7_pad_feeder_if.sv
// ----------------------------------------------------------------------------
// pkcs7_pad_feeder_if
// Byte-stream bus between the byte receiver, pkcs7_pad_feeder and create_block.
//   byte_valid_in / byte_in / last_in : upstream message byte (valid/ready)
//   ready_out                         : feeder accepts a byte this cycle
//   byte_out / add_new_out            : byte + one-cycle strobe to create_block
//   msg_done_out                      : one-cycle pulse after the final pad byte
//   busy_out                          : a message is in flight
// Modports: slave = feeder side, master = environment side.
// ----------------------------------------------------------------------------
interface pkcs7_pad_feeder_if;
    logic       byte_valid_in;
    logic [7:0] byte_in;
    logic       last_in;
    logic       ready_out;
    logic [7:0] byte_out;
    logic       add_new_out;
    logic       msg_done_out;
    logic       busy_out;

    modport slave (
        input  byte_valid_in, byte_in, last_in,
        output ready_out, byte_out, add_new_out, msg_done_out, busy_out
    );

    modport master (
        output byte_valid_in, byte_in, last_in,
        input  ready_out, byte_out, add_new_out, msg_done_out, busy_out
    );
endinterface

// File: rtl/pkcs7_pad_feeder.sv
// ----------------------------------------------------------------------------
// pkcs7_pad_feeder
// Forwards a message byte stream to create_block one byte per add_new_out
// pulse, then appends PKCS#7 padding so each message ends on a whole block.
// Ports:
//   clk_in    : system clock, rising edge
//   rst_n_in  : asynchronous assert, synchronous release, active low
//   bus       : pkcs7_pad_feeder_if.slave (handshake in, block bytes out)
// Parameters:
//   BLOCK_BYTES : bytes per cipher block (16 for PKCS#7)
//   MIN_GAP     : idle cycles forced after every add_new_out pulse (1..15)
// ----------------------------------------------------------------------------
module pkcs7_pad_feeder #(
    parameter int unsigned BLOCK_BYTES = 16,
    parameter int unsigned MIN_GAP     = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    pkcs7_pad_feeder_if.slave     bus
);

    typedef enum logic [1:0] {
        PASS = 2'd0,
        PAD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LOAD = 4'(MIN_GAP);
    localparam logic [4:0] BLK      = 5'(BLOCK_BYTES);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [3:0] gap_q;
    logic [4:0] pad_val_q;
    logic [4:0] pad_left_q;
    logic [7:0] byte_q;
    logic       add_new_q;
    logic       done_q;
    logic       busy_q;

    logic       ready_d;
    logic       xfer_d;
    logic [3:0] cnt_d;
    logic [4:0] pad_calc_d;

    assign ready_d = (state_q == PASS) && (gap_q == '0);
    assign xfer_d  = ready_d && bus.byte_valid_in;
    assign cnt_d   = cnt_q + 4'd1;
    // cnt_d is the block fill after this byte; a 4-bit wrap to 0 means a
    // full block, and BLK - 0 gives the required whole pad block of 16.
    assign pad_calc_d = BLK - {1'b0, cnt_d};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= PASS;
            cnt_q      <= '0;
            gap_q      <= '0;
            pad_val_q  <= '0;
            pad_left_q <= '0;
            byte_q     <= '0;
            add_new_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            add_new_q <= 1'b0;
            done_q    <= 1'b0;
            if (gap_q != '0) begin
                gap_q <= gap_q - 4'd1;
            end
            case (state_q)
                PASS: begin
                    if (xfer_d) begin
                        byte_q    <= bus.byte_in;
                        add_new_q <= 1'b1;
                        cnt_q     <= cnt_d;
                        gap_q     <= GAP_LOAD;
                        busy_q    <= 1'b1;
                        if (bus.last_in) begin
                            pad_val_q  <= pad_calc_d;
                            pad_left_q <= pad_calc_d;
                            state_q    <= PAD;
                        end
                    end
                end
                PAD: begin
                    if (gap_q == '0) begin
                        byte_q     <= {3'b000, pad_val_q};
                        add_new_q  <= 1'b1;
                        cnt_q      <= cnt_d;
                        gap_q      <= GAP_LOAD;
                        pad_left_q <= pad_left_q - 5'd1;
                        if (pad_left_q == 5'd1) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Entered on the edge that issued the last pad byte, so
                    // the done pulse lands one cycle after that pulse.
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= PASS;
                end
                default: state_q <= PASS;
            endcase
        end
    end

    assign bus.ready_out    = ready_d;
    assign bus.byte_out     = byte_q;
    assign bus.add_new_out  = add_new_q;
    assign bus.msg_done_out = done_q;
    assign bus.busy_out     = busy_q;

endmodule

// File: tb/tb_pkcs7_pad_feeder.sv
// ----------------------------------------------------------------------------
// tb_pkcs7_pad_feeder
// Directed bench for pkcs7_pad_feeder. dut_a runs with MIN_GAP=1, dut_b with
// MIN_GAP=3; both share the upstream drive, sel picks whose ready paces it.
// ----------------------------------------------------------------------------
module tb_pkcs7_pad_feeder;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       v     = 1'b0;
    logic [7:0] d     = 8'h00;
    logic       l     = 1'b0;
    bit         sel   = 1'b0;

    always #5 clk = ~clk;

    pkcs7_pad_feeder_if ifa();
    pkcs7_pad_feeder_if ifb();

    assign ifa.byte_valid_in = v;
    assign ifa.byte_in       = d;
    assign ifa.last_in       = l;
    assign ifb.byte_valid_in = v;
    assign ifb.byte_in       = d;
    assign ifb.last_in       = l;

    pkcs7_pad_feeder #(.BLOCK_BYTES(16), .MIN_GAP(1)) dut_a (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (ifa.slave)
    );

    pkcs7_pad_feeder #(.BLOCK_BYTES(16), .MIN_GAP(3)) dut_b (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (ifb.slave)
    );

    int n_checks   = 0;
    int n_errors   = 0;
    int n_timeouts = 0;

    // Pulse logs sampled on the falling edge.
    int         cyc = 0;
    logic [7:0] pa[$];
    int         ca[$];
    int         da[$];
    logic [7:0] pb[$];
    int         cb[$];
    int         db[$];
    int         busy_low_a  = 0;
    int         done_busy_a = 0;
    logic [3:0] cnt_done_a  = 4'hx;

    initial begin
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (ifa.add_new_out) begin
                pa.push_back(ifa.byte_out);
                ca.push_back(cyc);
                if (!ifa.busy_out) busy_low_a++;
            end
            if (ifa.msg_done_out) begin
                da.push_back(cyc);
                if (ifa.busy_out) done_busy_a++;
                cnt_done_a = dut_a.cnt_q;
            end
            if (ifb.add_new_out) begin
                pb.push_back(ifb.byte_out);
                cb.push_back(cyc);
            end
            if (ifb.msg_done_out) db.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        pa.delete(); ca.delete(); da.delete();
        pb.delete(); cb.delete(); db.delete();
        busy_low_a  = 0;
        done_busy_a = 0;
        cnt_done_a  = 4'hx;
        n_timeouts  = 0;
    endtask

    task automatic do_reset();
        v = 1'b0; d = 8'h00; l = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        clear_logs();
    endtask

    // Presents one byte and returns just after the transfer edge with valid
    // still high, so consecutive calls keep byte_valid_in asserted.
    task automatic send_byte(input logic [7:0] b, input logic lst);
        int t = 0;
        v = 1'b1; d = b; l = lst;
        @(negedge clk);
        while (!(sel ? ifb.ready_out : ifa.ready_out) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) n_timeouts++;
        @(posedge clk); #1;
        l = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] start, input int len, input bit keep_valid);
        for (int i = 0; i < len; i++) begin
            send_byte(start + 8'(i), (i == len - 1));
        end
        if (!keep_valid) v = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n, input int budget);
        int t = 0;
        while ((sel ? db.size() : da.size()) < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        check_eq(tag, sel ? db.size() : da.size(), n);
    endtask

    function automatic logic [7:0] get_p(input int idx);
        if (sel) return (idx < pb.size()) ? pb[idx] : 8'hxx;
        return (idx < pa.size()) ? pa[idx] : 8'hxx;
    endfunction

    // Expected stream: start, start+1, ... (len bytes), then padv copies of padv.
    task automatic check_msg(input string tag, input int off, input logic [7:0] start,
                             input int len, input int padv);
        for (int i = 0; i < len; i++) begin
            check_eq({tag, "_data"}, get_p(off + i), start + 8'(i));
        end
        for (int j = 0; j < padv; j++) begin
            check_eq({tag, "_pad"}, get_p(off + len + j), 8'(padv));
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        check_eq("rst_byte_out",  ifa.byte_out, 8'h00);
        check_eq("rst_add_new",   ifa.add_new_out, 1'b0);
        check_eq("rst_msg_done",  ifa.msg_done_out, 1'b0);
        check_eq("rst_busy",      ifa.busy_out, 1'b0);
        check_eq("rst_ready",     ifa.ready_out, 1'b1);
        // last_in without valid must do nothing
        l = 1'b1;
        repeat (4) @(posedge clk);
        #1 l = 1'b0;
        check_eq("last_no_valid_pulses", pa.size(), 0);
        check_eq("last_no_valid_busy",   ifa.busy_out, 1'b0);

        // ---------------- T1: 13 bytes -> pad 03 x3 ----------------
        do_reset();
        send_seq(8'h01, 13, 1'b0);
        wait_done("t1_done", 1, 400);
        check_eq("t1_pulses", pa.size(), 16);
        check_msg("t1", 0, 8'h01, 13, 3);
        check_eq("t1_done_timing", da[0], ca[15] + 1);
        check_eq("t1_timeouts", n_timeouts, 0);

        // ---------------- T2: full block -> 16 x 10 ----------------
        do_reset();
        send_seq(8'h01, 16, 1'b0);
        wait_done("t2_done", 1, 400);
        check_eq("t2_pulses", pa.size(), 32);
        check_msg("t2", 0, 8'h01, 16, 16);
        check_eq("t2_cnt_at_done", cnt_done_a, 4'h0);
        check_eq("t2_timeouts", n_timeouts, 0);

        // ---------------- T3: single AA -> 15 x 0F ----------------
        do_reset();
        send_seq(8'hAA, 1, 1'b0);
        wait_done("t3_done", 1, 400);
        check_eq("t3_pulses", pa.size(), 16);
        check_msg("t3", 0, 8'hAA, 1, 15);
        check_eq("t3_busy_low_on_pulse", busy_low_a, 0);
        check_eq("t3_busy_high_at_done", done_busy_a, 0);
        check_eq("t3_busy_after", ifa.busy_out, 1'b0);

        // ---------------- T4: MIN_GAP=3, valid held continuously ----------------
        do_reset();
        sel = 1'b1;
        send_seq(8'h21, 5, 1'b0);
        wait_done("t4_done", 1, 600);
        check_eq("t4_pulses", pb.size(), 16);
        check_msg("t4", 0, 8'h21, 5, 11);
        for (int i = 1; i < 16; i++) begin
            check_eq("t4_spacing", (i < cb.size()) ? cb[i] - cb[i-1] : -1, 4);
        end
        check_eq("t4_timeouts", n_timeouts, 0);
        sel = 1'b0;

        // ---------------- T5: reset during padding ----------------
        do_reset();
        send_seq(8'h01, 13, 1'b0);
        begin
            int t = 0;
            while (pa.size() < 14 && t < 200) begin
                @(negedge clk); #1;
                t++;
            end
        end
        check_eq("t5_pulses_before_rst", pa.size(), 14);
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_byte_out", ifa.byte_out, 8'h00);
        check_eq("t5_rst_add_new",  ifa.add_new_out, 1'b0);
        check_eq("t5_rst_msg_done", ifa.msg_done_out, 1'b0);
        check_eq("t5_rst_busy",     ifa.busy_out, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("t5_ready_after_rst", ifa.ready_out, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        check_eq("t5_no_more_pulses", pa.size(), 14);
        check_eq("t5_no_msg_done", da.size(), 0);
        clear_logs();
        send_seq(8'h55, 1, 1'b0);
        wait_done("t5_done", 1, 400);
        check_eq("t5_pulses", pa.size(), 16);
        check_msg("t5", 0, 8'h55, 1, 15);

        // ---------------- T6: back-to-back 5 then 20 bytes ----------------
        do_reset();
        send_seq(8'h01, 5, 1'b1);
        send_seq(8'h40, 20, 1'b0);
        wait_done("t6_done", 2, 800);
        check_eq("t6_pulses", pa.size(), 48);
        check_msg("t6_m1", 0, 8'h01, 5, 11);
        check_msg("t6_m2", 16, 8'h40, 20, 12);
        check_eq("t6_m2_after_done",
                 (ca.size() > 16 && da.size() > 0) ? (ca[16] > da[0]) : 0, 1);
        check_eq("t6_timeouts", n_timeouts, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
